// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps all ALU ops with corner and LFSR operands, one vector per clock,
// and folds every result into a 32-bit MISR that is compared against a golden signature.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

interface alu_if;
  import alu_pkg::*;
  aluop_t      alu_op;
  logic [31:0] port_A;
  logic [31:0] port_B;
  logic [31:0] outport;
  logic        neg;
  logic        overflow;
  logic        zero;
  modport alu (input alu_op, port_A, port_B, output neg, overflow, zero, outport);
  modport tb  (output alu_op, port_A, port_B, input neg, overflow, zero, outport);
endinterface

module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned N_VECTORS  = 64,
  parameter logic [31:0] SEED       = 32'hACE1_0001,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        abort,
  alu_if.tb           aluif,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);
  localparam int unsigned CNT_W  = $clog2(N_VECTORS);
  localparam int unsigned N_OPS  = 10;
  localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B = (~SEED_A == 32'h0) ? 32'h1 : ~SEED_A;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] vec_cnt, vec_nxt;
  logic [3:0]       op_idx;
  logic [31:0]      lfsr_a, lfsr_b;
  aluop_t           alu_op_q;
  logic [31:0]      port_a_q, port_b_q;
  logic [31:0]      misr_next;
  logic             last_vec, last_op, start_run, vec_nxt_corner;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic aluop_t op_at(input logic [3:0] idx);
    case (idx)
      4'd0:    return ALU_SLL;
      4'd1:    return ALU_SRL;
      4'd2:    return ALU_ADD;
      4'd3:    return ALU_SUB;
      4'd4:    return ALU_AND;
      4'd5:    return ALU_OR;
      4'd6:    return ALU_XOR;
      4'd7:    return ALU_NOR;
      4'd8:    return ALU_SLT;
      default: return ALU_SLTU;
    endcase
  endfunction

  // Fixed corner operands {port_A, port_B} for the first four vectors of every op.
  function automatic logic [63:0] corner(input logic [1:0] v);
    case (v)
      2'd0:    return {32'h0000_0000, 32'h0000_0000};
      2'd1:    return {32'hFFFF_FFFF, 32'h0000_0001};
      2'd2:    return {32'h7FFF_FFFF, 32'h0000_0001};
      default: return {32'h8000_0000, 32'hFFFF_FFFF};
    endcase
  endfunction

  assign aluif.alu_op = alu_op_q;
  assign aluif.port_A = port_a_q;
  assign aluif.port_B = port_b_q;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

  assign last_vec       = (vec_cnt == CNT_W'(N_VECTORS - 1));
  assign last_op        = (op_idx == 4'(N_OPS - 1));
  assign vec_nxt        = vec_cnt + CNT_W'(1);
  assign vec_nxt_corner = ((vec_nxt >> 2) == '0);
  assign start_run      = start && !abort && (state != RUN);
  assign misr_next      = {signature[30:0], signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                          ^ aluif.outport ^ {29'b0, aluif.neg, aluif.overflow, aluif.zero};

  always_comb begin
    // NOTE: defaults come first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_vec && last_op) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      signature <= 32'hFFFF_FFFF;
      pass      <= 1'b0;
      vec_cnt   <= '0;
      op_idx    <= '0;
      lfsr_a    <= SEED_A;
      lfsr_b    <= SEED_B;
      alu_op_q  <= ALU_SLL;
      port_a_q  <= '0;
      port_b_q  <= '0;
    end else if (abort) begin
      pass     <= 1'b0;
      vec_cnt  <= '0;
      op_idx   <= '0;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      alu_op_q <= ALU_SLL;
      port_a_q <= '0;
      port_b_q <= '0;
    end else if (start_run) begin
      signature <= 32'hFFFF_FFFF;
      pass      <= 1'b0;
      vec_cnt   <= '0;
      op_idx    <= '0;
      lfsr_a    <= SEED_A;
      lfsr_b    <= SEED_B;
      alu_op_q  <= ALU_SLL;
      port_a_q  <= '0;
      port_b_q  <= '0;
    end else if (state == RUN) begin
      // Sample the result of the vector on the ports and load the next vector on the same edge.
      signature <= misr_next;
      if (!last_vec) begin
        vec_cnt <= vec_nxt;
        lfsr_a  <= lfsr_step(lfsr_a);
        lfsr_b  <= lfsr_step(lfsr_b);
        if (vec_nxt_corner) {port_a_q, port_b_q} <= corner(vec_nxt[1:0]);
        else                {port_a_q, port_b_q} <= {lfsr_step(lfsr_a), lfsr_step(lfsr_b)};
      end else if (!last_op) begin
        vec_cnt  <= '0;
        op_idx   <= op_idx + 4'd1;
        lfsr_a   <= SEED_A;
        lfsr_b   <= SEED_B;
        alu_op_q <= op_at(op_idx + 4'd1);
        {port_a_q, port_b_q} <= corner(2'd0);
      end else begin
        pass <= (misr_next == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: behavioural ALU + signature model, directed and randomized runs.
module tb_alu_bist;
  import alu_pkg::*;

  localparam int          NV     = 8;
  localparam int          TOTAL  = 10 * NV;
  localparam int          BUDGET = TOTAL + 20;
  localparam logic [31:0] SEED_A = 32'hACE1_0001;
  localparam logic [31:0] SEED_B = ~32'hACE1_0001;

  function automatic logic [31:0] lfsr_after(input logic [31:0] s, input int n);
    logic [31:0] l;
    l = s;
    for (int i = 0; i < n; i++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    return l;
  endfunction

  // Operands {A, B} for vector v of any op.
  function automatic logic [63:0] vec_ref(input int v);
    case (v)
      0:       return {32'h0000_0000, 32'h0000_0000};
      1:       return {32'hFFFF_FFFF, 32'h0000_0001};
      2:       return {32'h7FFF_FFFF, 32'h0000_0001};
      3:       return {32'h8000_0000, 32'hFFFF_FFFF};
      default: return {lfsr_after(SEED_A, v), lfsr_after(SEED_B, v)};
    endcase
  endfunction

  function automatic aluop_t op_of(input int i);
    case (i)
      0:       return ALU_SLL;
      1:       return ALU_SRL;
      2:       return ALU_ADD;
      3:       return ALU_SUB;
      4:       return ALU_AND;
      5:       return ALU_OR;
      6:       return ALU_XOR;
      7:       return ALU_NOR;
      8:       return ALU_SLT;
      default: return ALU_SLTU;
    endcase
  endfunction

  // Returns {neg, overflow, zero, outport}; fault forces outport[0] to 0.
  function automatic logic [34:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input bit fault);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      0: r = a << b[4:0];
      1: r = a >> b[4:0];
      2: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~(a | b);
      8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r[31], ov, (r == 32'd0), fault ? {r[31:1], 1'b0} : r};
  endfunction

  function automatic logic [31:0] model_sig(input bit fault);
    logic [31:0] sig;
    logic [63:0] ab;
    logic [34:0] res;
    sig = 32'hFFFF_FFFF;
    for (int op = 0; op < 10; op++) begin
      for (int v = 0; v < NV; v++) begin
        ab  = vec_ref(v);
        res = alu_ref(op, ab[63:32], ab[31:0], fault);
        sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ res[31:0] ^ {29'b0, res[34:32]};
      end
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLDEN = model_sig(1'b0);

  logic        CLK, nRST, start, abort;
  logic        busy, done, pass;
  logic [31:0] signature;
  bit          fault;
  int          alu_idx;
  logic [34:0] alu_res;
  int          n_checks = 0;
  int          n_fail   = 0;

  alu_if aluif ();

  alu_bist #(.N_VECTORS(NV), .SEED(SEED_A), .GOLDEN_SIG(GOLDEN)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .aluif(aluif),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always_comb begin
    alu_idx = 0;
    for (int i = 0; i < 10; i++) if (op_of(i) == aluif.alu_op) alu_idx = i;
    alu_res = alu_ref(alu_idx, aluif.port_A, aluif.port_B, fault);
  end
  assign aluif.outport = alu_res[31:0];
  assign {aluif.neg, aluif.overflow, aluif.zero} = alu_res[34:32];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit with_sig);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_op"},   aluif.alu_op, ALU_SLL);
    check({tag, "_A"},    aluif.port_A, 32'h0);
    check({tag, "_B"},    aluif.port_B, 32'h0);
    if (with_sig) check({tag, "_sig"}, signature, 32'hFFFF_FFFF);
  endtask

  // Drives start so the next edge (E0) samples it; returns just after E0.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after E0: follows the run to DONE and checks length, vectors and result.
  task automatic run_body(input string tag, input bit check_vec, input bit noise,
                          input logic [31:0] exp_sig, input bit exp_pass);
    int          n;
    logic [63:0] ab;
    n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      if (check_vec && n < TOTAL) begin
        ab = vec_ref(n % NV);
        check({tag, "_vop"},  aluif.alu_op, op_of(n / NV));
        check({tag, "_vA"},   aluif.port_A, ab[63:32]);
        check({tag, "_vB"},   aluif.port_B, ab[31:0]);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (noise) start = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (noise) start = 1'b0;
    check({tag, "_len"},  n, TOTAL);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_sig"},  signature, exp_sig);
  endtask

  initial begin
    int k;
    start = 1'b0;
    abort = 1'b0;
    fault = 1'b0;
    nRST  = 1'b1;

    // Asynchronous reset asserted mid-cycle.
    #3 nRST = 1'b0;
    #1 check_idle("por", 1'b1);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    check_idle("idle", 1'b1);

    // Golden run with per-cycle vector checks.
    start_run();
    run_body("golden", 1'b1, 1'b0, GOLDEN, 1'b1);
    tick();
    check("done_held", done, 1'b1);
    check("last_vec_held_A", aluif.port_A, vec_ref(NV - 1) >> 32);

    // outport[0] stuck-at-0.
    fault = 1'b1;
    start_run();
    run_body("fault", 1'b0, 1'b0, model_sig(1'b1), 1'b0);
    check("fault_sig_differs", (signature != GOLDEN), 1'b1);
    fault = 1'b0;

    // Abort at E0+30, then restart.
    start_run();
    repeat (29) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort", 1'b0);
    tick();
    check("abort_stays_idle", busy, 1'b0);
    start_run();
    run_body("after_abort", 1'b0, 1'b0, GOLDEN, 1'b1);

    // nRST pulsed mid-cycle at E0+50, then a full run.
    start_run();
    repeat (49) tick();
    #3 nRST = 1'b0;
    #1 check_idle("midrst", 1'b1);
    #1 nRST = 1'b1;
    tick();
    start_run();
    run_body("after_rst", 1'b0, 1'b0, GOLDEN, 1'b1);

    // start held high throughout: ignored while busy, restarts from DONE.
    start = 1'b1;
    tick();
    run_body("hold", 1'b0, 1'b0, GOLDEN, 1'b1);
    tick();
    check("hold_restart_done", done, 1'b0);
    check("hold_restart_busy", busy, 1'b1);
    check("hold_restart_sig",  signature, 32'hFFFF_FFFF);
    check("hold_restart_op",   aluif.alu_op, ALU_SLL);
    check("hold_restart_A",    aluif.port_A, 32'h0);
    abort = 1'b1;
    tick();
    check("abort_wins_busy", busy, 1'b0);
    check("abort_wins_done", done, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    tick();
    check("abort_wins_idle", busy, 1'b0);

    // Randomized gaps, abort points and start noise while busy.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      start_run();
      k = int'($urandom_range(1, TOTAL - 1));
      repeat (k - 1) begin
        start = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("rand_abort_busy", busy, 1'b0);
      check("rand_abort_done", done, 1'b0);
      start_run();
      run_body("rand", 1'b1, 1'b1, GOLDEN, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
